// File: rtl/seg_pkg.sv
// Shared constants for the multiplexed seven-segment scan driver:
// hex glyph table, segment bit positions and the default slot length.
package seg_pkg;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  localparam int DEFAULT_SLOT_LOG2 = 14;

  // Active-high {g,f,e,d,c,b,a}; 'b' and 'd' are the lower-case forms.
  localparam logic [6:0] GLYPH_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/seg_hex_decoder.sv
// Combinational nibble-to-segment decoder producing active-high {dp,g..a};
// a blanked digit keeps its decimal point.
module seg_hex_decoder
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  input  logic       blank,
  output logic [7:0] seg
);

  // Glyph lookup with blanking of the a-g segments only.
  always_comb begin
    seg = 8'h00;
    if (blank) begin
      seg[SEG_G:SEG_A] = 7'h00;
    end else begin
      seg[SEG_G:SEG_A] = GLYPH_TABLE[nibble];
    end
    seg[SEG_DP] = dp;
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed N-digit seven-segment scanner with tear-free frame-aligned
// loading, leading-zero blanking, 16-level PWM brightness and frame strobe.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS    = 8,
  parameter int SLOT_LOG2     = DEFAULT_SLOT_LOG2,
  parameter bit ANODE_ACT_LOW = 1'b1,
  parameter bit SEG_ACT_LOW   = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic                    blank_lz,
  input  logic [3:0]              brightness,
  input  logic                    enable,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [7:0]              cathode,
  output logic                    frame_done
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0]      LAST_IDX    = IDX_W'(NUM_DIGITS - 1);
  localparam logic [SLOT_LOG2-1:0]  SLOT_MAX    = {SLOT_LOG2{1'b1}};
  localparam logic [NUM_DIGITS-1:0] ANODE_OFF   = {NUM_DIGITS{ANODE_ACT_LOW}};
  localparam logic [7:0]            CATHODE_OFF = {8{SEG_ACT_LOW}};

  logic [SLOT_LOG2-1:0]        slot_cnt_r;
  logic [IDX_W-1:0]            digit_idx_r;
  logic [NUM_DIGITS-1:0][3:0]  pend_val_r;
  logic [NUM_DIGITS-1:0]       pend_dp_r;
  logic                        pend_valid_r;
  logic [NUM_DIGITS-1:0][3:0]  disp_val_r;
  logic [NUM_DIGITS-1:0]       disp_dp_r;
  logic [NUM_DIGITS-1:0]       anode_r;
  logic [7:0]                  cathode_r;
  logic                        frame_done_r;

  logic                  slot_wrap_s;
  logic                  frame_end_s;
  logic [NUM_DIGITS-1:0] blank_vec_s;
  logic [NUM_DIGITS-1:0] onehot_s;
  logic [3:0]            digit_nib_s;
  logic                  digit_dp_s;
  logic                  digit_blank_s;
  logic                  pwm_on_s;
  logic [7:0]            seg_s;

  assign slot_wrap_s   = enable && (slot_cnt_r == SLOT_MAX);
  assign frame_end_s   = slot_wrap_s && (digit_idx_r == LAST_IDX);
  assign digit_nib_s   = disp_val_r[digit_idx_r];
  assign digit_dp_s    = disp_dp_r[digit_idx_r];
  assign digit_blank_s = blank_vec_s[digit_idx_r];
  assign pwm_on_s      = (slot_cnt_r[SLOT_LOG2-1 -: 4] <= brightness);
  assign onehot_s      = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << digit_idx_r;

  // A digit is a leading zero when it and every digit to its left are zero.
  always_comb begin
    logic zero_above;
    zero_above  = 1'b1;
    blank_vec_s = {NUM_DIGITS{1'b0}};
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_above     = zero_above & (disp_val_r[i] == 4'h0);
      blank_vec_s[i] = blank_lz & zero_above & (i != 0);
    end
  end

  seg_hex_decoder u_dec (
    .nibble (digit_nib_s),
    .dp     (digit_dp_s),
    .blank  (digit_blank_s),
    .seg    (seg_s)
  );

  // Slot counter, digit rotation and frame strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt_r   <= {SLOT_LOG2{1'b0}};
      digit_idx_r  <= {IDX_W{1'b0}};
      frame_done_r <= 1'b0;
    end else begin
      frame_done_r <= frame_end_s;
      if (enable) begin
        slot_cnt_r <= slot_cnt_r + {{(SLOT_LOG2-1){1'b0}}, 1'b1};
      end else begin
        slot_cnt_r <= slot_cnt_r;
      end
      if (slot_wrap_s) begin
        if (digit_idx_r == LAST_IDX) begin
          digit_idx_r <= {IDX_W{1'b0}};
        end else begin
          digit_idx_r <= digit_idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
        end
      end else begin
        digit_idx_r <= digit_idx_r;
      end
    end
  end

  // Shadow loading: a new load overrides the clear, so data loaded on the
  // boundary cycle waits for the next frame while display takes the old one.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_val_r   <= {(4*NUM_DIGITS){1'b0}};
      pend_dp_r    <= {NUM_DIGITS{1'b0}};
      pend_valid_r <= 1'b0;
      disp_val_r   <= {(4*NUM_DIGITS){1'b0}};
      disp_dp_r    <= {NUM_DIGITS{1'b0}};
    end else begin
      if (frame_end_s && pend_valid_r) begin
        disp_val_r   <= pend_val_r;
        disp_dp_r    <= pend_dp_r;
        pend_valid_r <= 1'b0;
      end else begin
        disp_val_r <= disp_val_r;
        disp_dp_r  <= disp_dp_r;
      end
      if (load) begin
        pend_val_r   <= value_in;
        pend_dp_r    <= dp_in;
        pend_valid_r <= 1'b1;
      end else begin
        pend_val_r <= pend_val_r;
        pend_dp_r  <= pend_dp_r;
      end
    end
  end

  // Anode and cathode registered together so digit changes are glitch-free.
  always_ff @(posedge clk) begin
    if (rst) begin
      anode_r   <= ANODE_OFF;
      cathode_r <= CATHODE_OFF;
    end else if (!enable) begin
      anode_r   <= ANODE_OFF;
      cathode_r <= CATHODE_OFF;
    end else begin
      anode_r   <= (pwm_on_s ? onehot_s : {NUM_DIGITS{1'b0}}) ^ ANODE_OFF;
      cathode_r <= seg_s ^ CATHODE_OFF;
    end
  end

  assign anode      = anode_r;
  assign cathode    = cathode_r;
  assign frame_done = frame_done_r;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Randomized self-checking bench for seg_scan_driver (4 digits, 64-cycle
// slots, active-low pins) against a frame-level arithmetic reference model.
module tb_seg_scan_driver;

  localparam int N    = 4;
  localparam int SLOT = 64;
  localparam int FRAME = N * SLOT;

  logic          clk = 1'b0;
  logic          rst;
  logic [15:0]   value_in;
  logic [3:0]    dp_in;
  logic          load;
  logic          blank_lz;
  logic [3:0]    brightness;
  logic          enable;
  logic [3:0]    anode;
  logic [7:0]    cathode;
  logic          frame_done;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: position within the frame plus shadow registers.
  int          m_t;
  logic [15:0] m_disp_val, m_pend_val;
  logic [3:0]  m_disp_dp, m_pend_dp;
  logic        m_pvalid;

  logic [7:0] glyph_low [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  seg_scan_driver #(
    .NUM_DIGITS    (N),
    .SLOT_LOG2     (6),
    .ANODE_ACT_LOW (1'b1),
    .SEG_ACT_LOW   (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .value_in   (value_in),
    .dp_in      (dp_in),
    .load       (load),
    .blank_lz   (blank_lz),
    .brightness (brightness),
    .enable     (enable),
    .anode      (anode),
    .cathode    (cathode),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_t = 0;
    m_disp_val = 16'h0; m_disp_dp = 4'h0;
    m_pend_val = 16'h0; m_pend_dp = 4'h0;
    m_pvalid = 1'b0;
  endtask

  // One clock: predict outputs from pre-edge state, advance model, compare.
  task automatic step();
    logic [3:0]  exp_an;
    logic [7:0]  exp_cat;
    logic        exp_fd;
    int          slot, idx;
    logic [15:0] upper;
    logic [3:0]  nib;
    slot = m_t % SLOT;
    idx  = m_t / SLOT;
    if (rst || !enable) begin
      exp_an = 4'hF; exp_cat = 8'hFF; exp_fd = 1'b0;
    end else begin
      exp_an  = ((slot / 4) <= int'(brightness)) ? ~(4'h1 << idx) : 4'hF;
      upper   = m_disp_val >> (4 * idx);
      nib     = upper[3:0];
      exp_cat = glyph_low[nib];
      if (blank_lz && idx > 0 && upper == 16'h0) exp_cat[6:0] = 7'h7F;
      exp_cat[7] = ~m_disp_dp[idx];
      exp_fd  = (m_t == FRAME - 1);
    end
    if (rst) begin
      model_reset();
    end else begin
      if (enable && m_t == FRAME - 1 && m_pvalid) begin
        m_disp_val = m_pend_val; m_disp_dp = m_pend_dp; m_pvalid = 1'b0;
      end
      if (load) begin
        m_pend_val = value_in; m_pend_dp = dp_in; m_pvalid = 1'b1;
      end
      if (enable) m_t = (m_t + 1) % FRAME;
    end
    @(posedge clk);
    #1;
    load = 1'b0;
    check_val("anode", 32'(anode), 32'(exp_an));
    check_val("cathode", 32'(cathode), 32'(exp_cat));
    check_val("frame_done", 32'(frame_done), 32'(exp_fd));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    value_in = v; dp_in = d; load = 1'b1;
    step();
  endtask

  initial begin
    model_reset();
    rst = 1'b1; value_in = 16'h0; dp_in = 4'h0; load = 1'b0;
    blank_lz = 1'b0; brightness = 4'hF; enable = 1'b0;
    #1;
    run(3);
    rst = 1'b0; enable = 1'b1;
    run(600);
    // Mid-frame load, visible only after the frame boundary.
    do_load(16'h12AF, 4'b0010);
    run(600);
    // Leading-zero blanking on and off.
    do_load(16'h0050, 4'b0000);
    blank_lz = 1'b1;
    run(600);
    blank_lz = 1'b0;
    run(300);
    brightness = 4'd3;
    run(300);
    brightness = 4'd0;
    run(260);
    brightness = 4'hF;
    // Load exactly on the boundary cycle with older data still pending.
    do_load(16'h1111, 4'h0);
    for (int k = 0; k < FRAME + 2 && m_t != FRAME - 1; k++) step();
    check_val("boundary_align", 32'(m_t), 32'(FRAME - 1));
    do_load(16'hBEEF, 4'h0);
    run(2 * FRAME + 10);
    // Freeze mid-slot, then reset mid-frame with pending data outstanding.
    run(30);
    enable = 1'b0;
    run(20);
    enable = 1'b1;
    run(100);
    do_load(16'h7777, 4'hF);
    rst = 1'b1;
    step();
    rst = 1'b0;
    run(FRAME + 20);
    // Randomized traffic.
    for (int c = 0; c < 4000; c++) begin
      int r;
      rst = 1'b0;
      r = int'($urandom_range(0, 999));
      if (r < 8) begin
        value_in = (r < 3) ? 16'($urandom_range(0, 255)) : 16'($urandom);
        dp_in = 4'($urandom);
        load = 1'b1;
      end else if (r < 11) begin
        brightness = 4'($urandom);
      end else if (r < 13) begin
        blank_lz = ~blank_lz;
      end else if (r < 15) begin
        enable = ~enable;
      end else if (r == 15) begin
        rst = 1'b1;
      end
      step();
    end
    rst = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
